// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART byte width and receive FIFO sizing
package uart_pkg;

    localparam int UART_WIDTH    = 8;
    localparam int RX_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_INC  = 2'b01,
        CNT_DEC  = 2'b10
    } cnt_op_e;

    // Net occupancy change for one cycle: a write and a read together cancel.
    function automatic cnt_op_e cnt_op(input logic wr, input logic rd);
        if (wr && !rd) begin
            return CNT_INC;
        end else if (rd && !wr) begin
            return CNT_DEC;
        end
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// rtl/rx_fifo_mem.sv - DEPTH x WIDTH byte store, synchronous write, registered read
module rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_WIDTH,
    parameter int DEPTH = RX_FIFO_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array contents carry no reset; stale bytes are unreachable once pointers clear.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register reads the pre-write value when both ports hit one address.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - UART receive FIFO with rx_done edge capture and sticky overrun
module rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_WIDTH,
    parameter int DEPTH = RX_FIFO_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rx_done,
    input  logic [WIDTH-1:0]       rx_data,
    input  logic                   rd_en,
    input  logic                   clear_overrun,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          rx_done_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          write_event;
    logic          rd_accept;
    logic          wr_accept;
    logic          drop;

    // Occupancy flags follow count directly.
    always_comb begin
        empty = (count == '0);
        full  = (count == CW'(DEPTH));
    end

    // A held strobe writes once; a pop while full makes room for the same-cycle write.
    always_comb begin
        write_event = rx_done && !rx_done_q;
        rd_accept   = rd_en && !empty;
        wr_accept   = write_event && (!full || rd_accept);
        drop        = write_event && full && !rd_accept;
    end

    // Edge history, pointers, occupancy and flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_done_q <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
            rd_valid  <= rd_accept;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (cnt_op(wr_accept, rd_accept))
                CNT_INC: count <= count + 1'b1;
                CNT_DEC: count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    rx_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (rx_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule
